// File: rtl/rx_packet_parser.sv
// Command packet framer for the async receiver byte stream.
// Frame: SYNC, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN and payload).
// A verified packet is held for the host, which reads the payload by address
// and releases it with pkt_ack.
module rx_packet_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_data_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_endofpacket,
  output logic              pkt_valid,
  output logic [7:0]        pkt_cmd,
  output logic [7:0]        pkt_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              pkt_ack,
  output logic              err_checksum,
  output logic              err_len,
  output logic              err_timeout,
  output logic              err_overrun
);

  typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CHK, HOLD} stateT;

  // 9 bits so MAX_LEN = 256 still compares correctly against an 8-bit LEN
  localparam logic [8:0] MaxLen9 = 9'(MAX_LEN);

  stateT       state;
  logic [7:0]  cmdReg;
  logic [7:0]  lenReg;
  logic [7:0]  chk;
  logic [8:0]  cnt;
  logic [7:0]  payloadBuf [0:(1<<ADDR_W)-1];

  // Frame decoder, host handshake and error pulses; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      cmdReg       <= '0;
      lenReg       <= '0;
      chk          <= '0;
      cnt          <= '0;
      pkt_valid    <= 1'b0;
      pkt_cmd      <= '0;
      pkt_len      <= '0;
      err_checksum <= 1'b0;
      err_len      <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      err_checksum <= 1'b0;
      err_len      <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
      if (state == HOLD) begin
        // held packet is frozen: incoming bytes are dropped, SYNC included
        if (rx_data_ready) err_overrun <= 1'b1;
        if (pkt_ack) begin
          pkt_valid <= 1'b0;
          state     <= HUNT;
        end
      end else if (rx_data_ready) begin
        // a byte wins over a simultaneous line-idle gap
        case (state)
          HUNT: begin
            chk <= '0;
            if (rx_data == SYNC_BYTE) state <= CMD;
          end
          CMD: begin
            cmdReg <= rx_data;
            chk    <= rx_data;
            state  <= LEN;
          end
          LEN: begin
            chk    <= chk ^ rx_data;
            lenReg <= rx_data;
            cnt    <= '0;
            if ({1'b0, rx_data} > MaxLen9) begin
              err_len <= 1'b1;
              state   <= HUNT;
            end else if (rx_data == 8'd0) begin
              state <= CHK;
            end else begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            chk <= chk ^ rx_data;
            cnt <= cnt + 9'd1;
            if (cnt + 9'd1 == {1'b0, lenReg}) state <= CHK;
          end
          CHK: begin
            if ((chk ^ rx_data) == 8'd0) begin
              pkt_valid <= 1'b1;
              pkt_cmd   <= cmdReg;
              pkt_len   <= lenReg;
              state     <= HOLD;
            end else begin
              err_checksum <= 1'b1;
              state        <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end else if (rx_endofpacket && state != HUNT) begin
        err_timeout <= 1'b1;
        state       <= HUNT;
      end
    end
  end

  // Payload storage; only written while collecting payload, so frozen in HOLD
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && rx_data_ready) payloadBuf[cnt[ADDR_W-1:0]] <= rx_data;
  end

  // Registered host read port, one cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= payloadBuf[rd_addr];
  end

endmodule

// File: tb/tb_rx_packet_parser.sv
// Self-checking bench for rx_packet_parser: queue-based frame model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_rx_packet_parser;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MAXLEN = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_data_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_endofpacket = 1'b0;
  logic       pkt_valid;
  logic [7:0] pkt_cmd;
  logic [7:0] pkt_len;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       pkt_ack = 1'b0;
  logic       err_checksum, err_len, err_timeout, err_overrun;

  int checks = 0;
  int errors = 0;

  rx_packet_parser #(.SYNC_BYTE(SYNC), .MAX_LEN(MAXLEN), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .rx_endofpacket(rx_endofpacket), .pkt_valid(pkt_valid), .pkt_cmd(pkt_cmd),
    .pkt_len(pkt_len), .rd_addr(rd_addr), .rd_data(rd_data), .pkt_ack(pkt_ack),
    .err_checksum(err_checksum), .err_len(err_len), .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] frameQ[$];
  bit         inFrame;
  bit         mValid;
  logic [7:0] mCmd, mLen;
  logic [7:0] mBuf [0:255];
  bit         eChk, eLen, eTo, eOvr;
  bit         expRdOk;
  logic [7:0] expRd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameQ.delete();
      inFrame = 0; mValid = 0; mCmd = '0; mLen = '0;
      eChk = 0; eLen = 0; eTo = 0; eOvr = 0; expRdOk = 0; expRd = '0;
    end else begin
      logic [7:0] x;
      eChk = 0; eLen = 0; eTo = 0; eOvr = 0;
      expRdOk = mValid && (int'(rd_addr) < int'(mLen));
      expRd   = mBuf[rd_addr];
      if (mValid) begin
        if (rx_data_ready) eOvr = 1;
        if (pkt_ack) mValid = 0;
      end else if (rx_data_ready) begin
        if (!inFrame) begin
          if (rx_data == SYNC) begin inFrame = 1; frameQ.delete(); end
        end else begin
          frameQ.push_back(rx_data);
          if (frameQ.size() == 2 && int'(frameQ[1]) > MAXLEN) begin
            eLen = 1; inFrame = 0;
          end else if (frameQ.size() >= 2 && frameQ.size() == int'(frameQ[1]) + 3) begin
            x = '0;
            foreach (frameQ[i]) x ^= frameQ[i];
            if (x == 8'd0) begin
              mValid = 1; mCmd = frameQ[0]; mLen = frameQ[1];
              for (int i = 0; i < int'(mLen); i++) mBuf[i] = frameQ[2+i];
            end else begin
              eChk = 1;
            end
            inFrame = 0;
          end
        end
      end else if (rx_endofpacket && inFrame) begin
        eTo = 1; inFrame = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int nChk = 0, nLen = 0, nTo = 0, nOvr = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("pkt_valid", pkt_valid, mValid);
      check("pkt_cmd", pkt_cmd, mCmd);
      check("pkt_len", pkt_len, mLen);
      check("err_checksum", err_checksum, eChk);
      check("err_len", err_len, eLen);
      check("err_timeout", err_timeout, eTo);
      check("err_overrun", err_overrun, eOvr);
      if (expRdOk) check("rd_data", rd_data, expRd);
      if (err_checksum) nChk++;
      if (err_len) nLen++;
      if (err_timeout) nTo++;
      if (err_overrun) nOvr++;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] txq[$];

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic eop);
    rx_data_ready = 1'b1; rx_data = b; rx_endofpacket = eop;
    tick();
    rx_data_ready = 1'b0; rx_endofpacket = 1'b0;
  endtask

  task automatic sendQ(input int gap);
    foreach (txq[i]) begin
      sendByte(txq[i], 1'b0);
      repeat (gap) tick();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic ack();
    pkt_ack = 1'b1; tick(); pkt_ack = 1'b0;
  endtask

  task automatic readCheck(input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a; tick();
    check("rd_lit", rd_data, exp);
  endtask

  task automatic goodFrame(input int gap);
    txq = '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h02};
    sendQ(gap);
  endtask

  int base;

  initial begin
    // reset state
    idle(3);
    check("rst_valid", pkt_valid, 1'b0);
    check("rst_cmd", pkt_cmd, 8'h00);
    check("rst_len", pkt_len, 8'h00);
    check("rst_rd", rd_data, 8'h00);
    rst_n = 1'b1;
    idle(2);

    // 1: good frame
    goodFrame(0);
    check("t1_valid", pkt_valid, 1'b1);
    check("t1_cmd", pkt_cmd, 8'h01);
    check("t1_len", pkt_len, 8'h03);
    readCheck(4'd0, 8'h11);
    readCheck(4'd1, 8'h22);
    readCheck(4'd2, 8'h33);
    ack();
    check("t1_ack", pkt_valid, 1'b0);
    idle(1);

    // 2: bad checksum then good frame
    base = nChk;
    txq = '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    sendQ(1);
    idle(2);
    check("t2_chk_pulses", nChk - base, 1);
    check("t2_valid", pkt_valid, 1'b0);
    goodFrame(1);
    check("t2_good", pkt_valid, 1'b1);
    ack();

    // 3: zero length with leading noise
    base = nChk + nLen + nTo + nOvr;
    txq = '{8'h00, 8'hFF, 8'hA5, 8'h7E, 8'h00, 8'h7E};
    sendQ(0);
    check("t3_valid", pkt_valid, 1'b1);
    check("t3_cmd", pkt_cmd, 8'h7E);
    check("t3_len", pkt_len, 8'h00);
    idle(2);
    check("t3_no_err", nChk + nLen + nTo + nOvr - base, 0);
    ack();

    // 4: LEN limit
    base = nLen;
    txq = '{8'hA5, 8'h01, 8'h11};
    sendQ(0);
    idle(2);
    check("t4_len_pulses", nLen - base, 1);
    txq = '{8'hA5, 8'h01, 8'h10};
    for (int i = 0; i < 16; i++) txq.push_back(8'h10 + 8'(i));
    txq.push_back(8'h11);
    sendQ(0);
    check("t4_valid", pkt_valid, 1'b1);
    check("t4_len", pkt_len, 8'h10);
    readCheck(4'd0, 8'h10);
    readCheck(4'd15, 8'h1F);

    // 5b: overrun while held, gap in HOLD ignored
    base = nOvr;
    sendByte(8'h55, 1'b0);
    sendByte(8'hA5, 1'b0);
    rx_endofpacket = 1'b1; tick(); rx_endofpacket = 1'b0;
    idle(1);
    check("t5_ovr_pulses", nOvr - base, 2);
    check("t5_hold_cmd", pkt_cmd, 8'h01);
    check("t5_hold_len", pkt_len, 8'h10);
    readCheck(4'd5, 8'h15);
    // ack together with a byte: overrun and release
    rx_data_ready = 1'b1; rx_data = 8'hA5; pkt_ack = 1'b1;
    tick();
    rx_data_ready = 1'b0; pkt_ack = 1'b0;
    check("t5_ack_valid", pkt_valid, 1'b0);
    idle(1);
    check("t5_ack_ovr", nOvr - base, 3);

    // 5a: timeout mid-payload, then good frame with a coincident gap on a byte
    base = nTo;
    txq = '{8'hA5, 8'h01, 8'h03, 8'h11};
    sendQ(0);
    rx_endofpacket = 1'b1; tick(); rx_endofpacket = 1'b0;
    idle(2);
    check("t5_to_pulses", nTo - base, 1);
    sendByte(8'hA5, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'h03, 1'b1);
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b1);
    sendByte(8'h33, 1'b0);
    sendByte(8'h02, 1'b0);
    check("t5_good", pkt_valid, 1'b1);
    check("t5_to_total", nTo - base, 1);
    ack();
    idle(1);

    // 6: reset mid-payload
    txq = '{8'hA5, 8'h01, 8'h03, 8'h11};
    sendQ(0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", pkt_valid, 1'b0);
    check("t6_rst_cmd", pkt_cmd, 8'h00);
    check("t6_rst_len", pkt_len, 8'h00);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    goodFrame(0);
    check("t6_valid", pkt_valid, 1'b1);
    check("t6_cmd", pkt_cmd, 8'h01);
    readCheck(4'd2, 8'h33);
    ack();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
